// File: rtl/fetch_sequencer.sv
// Purpose: instruction fetch sequencer; drives the imem address from the PC, buffers fetched words for decode.
// Latency: the word at address A appears at OutInstr one cycle after PC==A, provided the FIFO has room.
// Backpressure: OutReady low fills the prefetch FIFO, then fetching stalls with the PC held.
//
// Ports:
//   Clk, Reset          rising-edge clock, asynchronous active-low reset
//   InstrAddress        byte address to imem (continuous copy of PC)
//   InstrData           combinational imem read data for InstrAddress
//   OutValid/OutReady   decode handshake; OutInstr/OutPCPlus4 carry the FIFO head
//   Redirect, RedirectTarget  flush and reload PC (low two target bits dropped)
//   Halt                level; stops new fetches while high
//   Misaligned          one-cycle pulse after a redirect whose target had bits [1:0] != 0
//   FetchFault          set when a fetch is attempted out of range, cleared by redirect
//   Halted              sequencer is in the HALTED state

// Purpose: generic synchronous FIFO with flush; head is presented combinationally.
// Latency: a pushed entry is visible at o_dat the cycle after the push when the FIFO was empty.
// Backpressure: caller must not push while o_full unless it pops in the same cycle.
module sync_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic         o_vld,
  output logic         o_full,
  output logic [W-1:0] o_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [W-1:0]  r_last;
  logic          w_pop;

  assign o_vld  = (r_count != '0);
  assign o_full = (r_count == (AW+1)'(DEPTH));
  assign w_pop  = i_pop & o_vld;
  // When empty, keep showing the most recently popped entry instead of a stale slot.
  assign o_dat  = o_vld ? r_mem[r_rptr] : r_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_push_dat;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_last <= r_mem[r_rptr];
        r_rptr <= r_rptr + 1'b1;
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int          DEPTH     = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] InstrAddress,
  input  logic [31:0] InstrData,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInstr,
  output logic [31:0] OutPCPlus4,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic        Halt,
  output logic        Misaligned,
  output logic        FetchFault,
  output logic        Halted
);
  // 33-bit limit so a full 4 GiB memory would not overflow the comparison.
  localparam logic [32:0] C_LIMIT = 33'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {S_RUN, S_HALTED, S_FAULT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_plus4;
  logic        r_misaligned;
  logic        w_push;
  logic        w_flush;
  logic        w_pop;
  logic        w_full;
  logic        w_space;
  logic        w_in_range;
  logic [63:0] w_head;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_in_range = ({1'b0, r_pc} < C_LIMIT);
  assign w_pop      = OutValid & OutReady;
  // A pop frees a slot in the same cycle, which keeps 1 instr/cycle with a full FIFO.
  assign w_space    = !w_full || w_pop;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    if (Redirect) begin
      w_flush     = 1'b1;
      w_pc_nxt    = {RedirectTarget[31:2], 2'b00};
      w_state_nxt = Halt ? S_HALTED : S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          if (Halt) begin
            w_state_nxt = S_HALTED;
          end else if (w_space) begin
            if (w_in_range) begin
              w_push   = 1'b1;
              w_pc_nxt = w_pc_plus4;
            end else begin
              // PC stays put so the faulting address remains visible.
              w_state_nxt = S_FAULT;
            end
          end
        end
        S_HALTED: if (!Halt) w_state_nxt = S_RUN;
        S_FAULT:  w_state_nxt = S_FAULT;
        default:  w_state_nxt = S_RUN;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= S_RUN;
      r_pc         <= RESET_PC;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_misaligned <= Redirect && (RedirectTarget[1:0] != 2'b00);
    end
  end

  sync_fifo #(
    .W     (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (Clk),
    .i_rst_n    (Reset),
    .i_flush    (w_flush),
    .i_push     (w_push),
    .i_push_dat ({InstrData, w_pc_plus4}),
    .i_pop      (w_pop),
    .o_vld      (OutValid),
    .o_full     (w_full),
    .o_dat      (w_head)
  );

  assign InstrAddress = r_pc;
  assign OutInstr     = w_head[63:32];
  assign OutPCPlus4   = w_head[31:0];
  assign Misaligned   = r_misaligned;
  assign FetchFault   = (r_state == S_FAULT);
  assign Halted       = (r_state == S_HALTED);
endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  logic        Clk;
  logic        Reset;
  logic [31:0] InstrAddress;
  logic [31:0] InstrData;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutInstr;
  logic [31:0] OutPCPlus4;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        Halt;
  logic        Misaligned;
  logic        FetchFault;
  logic        Halted;

  logic [31:0] imem [1024];
  int n_chk;
  int n_pass;

  fetch_sequencer #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WORDS (1024),
    .DEPTH     (2)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .InstrAddress   (InstrAddress),
    .InstrData      (InstrData),
    .OutValid       (OutValid),
    .OutReady       (OutReady),
    .OutInstr       (OutInstr),
    .OutPCPlus4     (OutPCPlus4),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .Halt           (Halt),
    .Misaligned     (Misaligned),
    .FetchFault     (FetchFault),
    .Halted         (Halted)
  );

  assign InstrData = imem[InstrAddress[11:2]];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Asserts reset one unit after an edge, releases it between edges two cycles later.
  task automatic do_reset(input logic rdy);
    Reset = 1'b0;
    Redirect = 1'b0;
    RedirectTarget = 32'h0;
    Halt = 1'b0;
    OutReady = rdy;
    tick();
    tick();
    Reset = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    for (int i = 0; i < 1024; i++) imem[i] = 32'hA500_0000 | i;
    imem[0] = 32'h2008_0005;
    imem[1] = 32'h2009_0003;
    imem[2] = 32'h0109_5020;
    imem[3] = 32'hAC0A_0000;

    Reset = 1'b1;
    Redirect = 1'b0;
    RedirectTarget = 32'h0;
    Halt = 1'b0;
    OutReady = 1'b1;
    #2 Reset = 1'b0;
    #1;
    chk("rst_vld", OutValid, 1'b0);
    chk("rst_instr", OutInstr, 32'h0);
    chk("rst_pcp4", OutPCPlus4, 32'h0);
    chk("rst_mis", Misaligned, 1'b0);
    chk("rst_fault", FetchFault, 1'b0);
    chk("rst_halted", Halted, 1'b0);
    chk("rst_addr", InstrAddress, 32'h0);

    // Streaming at one instruction per cycle.
    do_reset(1'b1);
    tick(); chk("s0_vld", OutValid, 1'b1); chk("s0_instr", OutInstr, 32'h2008_0005); chk("s0_pcp4", OutPCPlus4, 32'd4);
    tick(); chk("s1_vld", OutValid, 1'b1); chk("s1_instr", OutInstr, 32'h2009_0003); chk("s1_pcp4", OutPCPlus4, 32'd8);
    tick(); chk("s2_vld", OutValid, 1'b1); chk("s2_instr", OutInstr, 32'h0109_5020); chk("s2_pcp4", OutPCPlus4, 32'd12);
    tick(); chk("s3_vld", OutValid, 1'b1); chk("s3_instr", OutInstr, 32'hAC0A_0000); chk("s3_pcp4", OutPCPlus4, 32'd16);

    // Backpressure: FIFO fills with two entries, PC parks at 8.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_pc", InstrAddress, 32'd8);
    chk("bp_vld", OutValid, 1'b1);
    chk("bp_head", OutInstr, 32'h2008_0005);
    OutReady = 1'b1;
    tick(); chk("bp_d1", OutInstr, 32'h2009_0003); chk("bp_d1p", OutPCPlus4, 32'd8);
    tick(); chk("bp_d2", OutInstr, 32'h0109_5020); chk("bp_d2p", OutPCPlus4, 32'd12);
    tick(); chk("bp_d3", OutInstr, 32'hAC0A_0000); chk("bp_d3v", OutValid, 1'b1);

    // Misaligned redirect with a full FIFO.
    do_reset(1'b0);
    tick(); tick(); tick();
    chk("rd_pre_pc", InstrAddress, 32'd8);
    Redirect = 1'b1;
    RedirectTarget = 32'h0000_0042;
    tick();
    Redirect = 1'b0;
    chk("rd_vld", OutValid, 1'b0);
    chk("rd_pc", InstrAddress, 32'h40);
    chk("rd_mis", Misaligned, 1'b1);
    tick();
    chk("rd_mis_end", Misaligned, 1'b0);
    chk("rd_instr", OutInstr, 32'hA500_0010);
    chk("rd_pcp4", OutPCPlus4, 32'h44);

    // Fetch fault at the top of memory; queued entries still drain.
    do_reset(1'b0);
    Redirect = 1'b1;
    RedirectTarget = 32'h0000_0FF8;
    tick();
    Redirect = 1'b0;
    chk("ff_mis", Misaligned, 1'b0);
    tick(); tick(); tick();
    chk("ff_pc_full", InstrAddress, 32'h1000);
    chk("ff_nofault", FetchFault, 1'b0);
    OutReady = 1'b1;
    tick();
    chk("ff_fault", FetchFault, 1'b1);
    chk("ff_pc", InstrAddress, 32'h1000);
    chk("ff_q_vld", OutValid, 1'b1);
    chk("ff_q_instr", OutInstr, 32'hA500_03FF);
    chk("ff_q_pcp4", OutPCPlus4, 32'h1000);
    tick();
    chk("ff_drained", OutValid, 1'b0);
    chk("ff_sticky", FetchFault, 1'b1);
    chk("ff_pc_hold", InstrAddress, 32'h1000);
    Redirect = 1'b1;
    RedirectTarget = 32'h0;
    tick();
    Redirect = 1'b0;
    chk("ff_clear", FetchFault, 1'b0);
    chk("ff_rpc", InstrAddress, 32'h0);
    tick();
    chk("ff_resume", OutInstr, 32'h2008_0005);
    chk("ff_resume_p", OutPCPlus4, 32'd4);

    // Halt for four cycles while draining.
    do_reset(1'b0);
    tick(); tick();
    Halt = 1'b1;
    OutReady = 1'b1;
    tick();
    chk("h1_halted", Halted, 1'b1);
    chk("h1_head", OutInstr, 32'h2009_0003);
    chk("h1_pc", InstrAddress, 32'd8);
    tick();
    chk("h2_vld", OutValid, 1'b0);
    tick(); tick();
    chk("h4_halted", Halted, 1'b1);
    chk("h4_pc", InstrAddress, 32'd8);
    Halt = 1'b0;
    tick();
    chk("h5_halted", Halted, 1'b0);
    chk("h5_vld", OutValid, 1'b0);
    tick();
    chk("h6_instr", OutInstr, 32'h0109_5020);
    chk("h6_pcp4", OutPCPlus4, 32'd12);

    // Halt and redirect together: redirect applied, state goes HALTED.
    Halt = 1'b1;
    Redirect = 1'b1;
    RedirectTarget = 32'h20;
    tick();
    Redirect = 1'b0;
    chk("hr_halted", Halted, 1'b1);
    chk("hr_pc", InstrAddress, 32'h20);
    chk("hr_vld", OutValid, 1'b0);
    Halt = 1'b0;
    tick(); tick();
    chk("hr_resume", OutInstr, 32'hA500_0008);

    // Asynchronous reset between edges.
    do_reset(1'b1);
    tick(); tick(); tick();
    chk("ar_pre_vld", OutValid, 1'b1);
    #2 Reset = 1'b0;
    #1;
    chk("ar_vld", OutValid, 1'b0);
    chk("ar_instr", OutInstr, 32'h0);
    chk("ar_addr", InstrAddress, 32'h0);
    tick();
    Reset = 1'b1;
    tick();
    chk("ar_first_p", OutPCPlus4, 32'd4);
    chk("ar_first_i", OutInstr, 32'h2008_0005);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
